// File: rtl/scmp_bus_responder.sv
// SC/MP target-side bus responder: decodes core bus cycles, runs a req/ack
// transaction to memory, stalls the core with bus_hold, handles timeout/errors.
module scmp_bus_responder #(
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [7:0]  IDLE_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_ADS_n,
  input  logic        bus_RD_n,
  input  logic        bus_WR_n,
  input  logic        bus_F_R,
  input  logic        bus_F_I,
  input  logic        bus_F_D,
  input  logic        bus_F_H,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        bus_hold,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [3:0]  flags,
  output logic        halt_pulse,
  output logic        bus_err
);

  localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_REQ, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          ads_prev_q, ads_prev_d;
  logic [7:0]    bus_rdata_q, bus_rdata_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    flags_q, flags_d;
  logic          halt_q, halt_d;
  logic          err_q, err_d;

  logic ads, rd, wr, ads_edge;

  always_comb begin
    ads      = ~bus_ADS_n;
    rd       = ~bus_RD_n;
    wr       = ~bus_WR_n;
    // ads_prev_q holds last sampled ADS_n level; a new strobe is high->low
    ads_edge = ads & ads_prev_q;

    state_d     = state_q;
    count_d     = count_q;
    ads_prev_d  = bus_ADS_n;
    bus_rdata_d = bus_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    flags_d     = flags_q;
    halt_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ads) begin
          mem_addr_d = bus_addr;
          flags_d    = {bus_F_H, bus_F_D, bus_F_I, bus_F_R};
          halt_d     = bus_F_H;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ads) begin
          mem_addr_d = bus_addr;
          flags_d    = {bus_F_H, bus_F_D, bus_F_I, bus_F_R};
          halt_d     = bus_F_H;
        end else if (rd && wr) begin
          err_d       = 1'b1;
          bus_rdata_d = IDLE_DATA;
          state_d     = S_DONE;
        end else if (rd || wr) begin
          mem_we_d = wr;
          if (wr) mem_wdata_d = bus_wdata;
          count_d  = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (ads_edge) err_d = 1'b1;
        if (mem_ack) begin
          if (!mem_we_q) bus_rdata_d = mem_rdata;
          state_d = S_DONE;
        end else if (count_q == CNT_LAST) begin
          if (!mem_we_q) bus_rdata_d = IDLE_DATA;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (count_q != '1) begin
          count_d = count_q + 1'b1;
        end
      end
      S_DONE: begin
        if (ads_edge) err_d = 1'b1;
        if (!rd && !wr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      ads_prev_q  <= 1'b1;
      bus_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      flags_q     <= '0;
      halt_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ads_prev_q  <= ads_prev_d;
      bus_rdata_q <= bus_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      flags_q     <= flags_d;
      halt_q      <= halt_d;
      err_q       <= err_d;
    end
  end

  assign mem_req    = (state_q == S_REQ);
  assign bus_hold   = (state_q == S_REQ);
  assign bus_rdata  = bus_rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign flags      = flags_q;
  assign halt_pulse = halt_q;
  assign bus_err    = err_q;

endmodule

// File: doc/scmp_bus_responder.md
# scmp_bus_responder

Target-side bus responder for the SC/MP core: decodes the core's address-strobe/read/write bus cycle, latches address and status flags, runs a req/ack transaction to a memory or peripheral port, stalls the core with `bus_hold` until the transaction completes, and returns read data. It sits between the core's external bus pins and the system memory map. It also owns the wait-state timeout and bus-protocol error reporting.

## Interface
- `TIMEOUT`, 15: max cycles in REQ without `mem_ack` before the access is abandoned (1..255).
- `IDLE_DATA`, 8'hFF: read data returned on timeout or protocol error.
- Clocking and reset (decided): one clock; reset is asynchronous and active-high.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `bus_ADS_n`  in  1  address strobe, active low.
- `bus_RD_n`  in  1  read strobe, active low.
- `bus_WR_n`  in  1  write strobe, active low.
- `bus_F_R`, `bus_F_I`, `bus_F_D`, `bus_F_H`  in  1 each  status flags; valid only while `bus_ADS_n`=0.
- `bus_addr`  in  16  address; valid while `bus_ADS_n`=0.
- `bus_wdata`  in  8  core write data; valid while `bus_WR_n`=0.
- `bus_rdata`  out  8  read data to core, registered.
- `bus_hold`  out  1  stall request to core; core holds its strobes while 1.
- `mem_req`  out  1  transaction request, level.
- `mem_we`  out  1  1=write, 0=read; stable while `mem_req`=1.
- `mem_addr`  out  16  latched address.
- `mem_wdata`  out  8  latched write data.
- `mem_rdata`  in  8  read data; valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle completion pulse.
- `flags`  out  4  latched {H,D,I,R} of the current/last cycle.
- `halt_pulse`  out  1  one-cycle pulse: address latched with F_H=1.
- `bus_err`  out  1  one-cycle pulse on timeout or protocol error.

## Operation
- States: IDLE, ADDR, REQ, DONE.
- IDLE: `bus_ADS_n`=0 sampled → latch `mem_addr`, `flags`; pulse `halt_pulse` if F_H; go ADDR.
- ADDR: `bus_ADS_n`=0 again → re-latch (no error). `RD_n`=0 xor `WR_n`=0 → set `mem_we`, latch `mem_wdata` if write, go REQ. Both low → pulse `bus_err`, load `bus_rdata`=IDLE_DATA, go DONE.
- REQ: `mem_req`=1, `bus_hold`=1, timeout counter increments each cycle from 0. `mem_ack`=1 → if read, `bus_rdata`<=`mem_rdata`; go DONE. Counter reaches TIMEOUT without ack → `bus_rdata`<=IDLE_DATA (reads), pulse `bus_err`, go DONE.
- DONE: `mem_req`=0, `bus_hold`=0; wait until `RD_n`=1 and `WR_n`=1 → IDLE.
- `bus_ADS_n`=0 in REQ or DONE: ignored, `bus_err` pulsed once per occurrence edge; current access completes normally.
- `mem_ack` outside REQ: ignored (late ack after timeout discarded).
- Counter width `$clog2(TIMEOUT+1)`; saturating, cleared on REQ entry.

## Timing
- Reset: state IDLE; `bus_rdata`=0, `bus_hold`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `flags`=0, `halt_pulse`=0, `bus_err`=0. Reset mid-access drops `mem_req` immediately (async).
- Strobes sampled at rising edge; `flags`/`mem_addr` valid the cycle after ADS_n sampled low.
- `mem_req`, `bus_hold` rise the cycle after data strobe sampled low (registered).
- `mem_ack` at edge N → `bus_rdata` valid and `bus_hold`=0 from cycle N+1; `mem_req` low from N+1.
- Minimum access: ADS cycle, strobe cycle, 1 REQ cycle with same-cycle ack → 3 cycles to DONE.
- Timeout: `bus_err` high the cycle after the TIMEOUT-th REQ cycle, coincident with `bus_hold` falling.

## Test plan
- Read 0x1234, F_I=1, ack after 2 REQ cycles with `mem_rdata`=0x5A → `mem_we`=0, `flags`=4'b0010, `bus_hold` high 2 cycles, `bus_rdata`=0x5A.
- Write 0x0FFE data 0xC3, ack in first REQ cycle → `mem_we`=1, `mem_addr`=0x0FFE, `mem_wdata`=0xC3, `bus_err`=0.
- Read with no ack, TIMEOUT=15 → `mem_req` high exactly 15 cycles, `bus_err` one pulse, `bus_rdata`=0xFF; later ack ignored.
- ADS with F_H=1 → `halt_pulse` one cycle; RD_n and WR_n low together → `bus_err`, no `mem_req`, `bus_rdata`=0xFF.
- ADS reasserted during REQ → one `bus_err` pulse, access completes with original address; `rst` asserted in REQ → all outputs 0 asynchronously, state IDLE.
